// File: rtl/stim_player.sv
// stim_player: time-stamped stimulus player.
//   A producer preloads {in_time, in_sig} samples into a DEPTH-entry FIFO.
//   Playback begins on a start pulse. During playback, each head sample is
//   applied to sig_out once time_curr reaches its timestamp.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   time_curr                current emulated time (monotonic, unsigned)
//   in_valid/in_ready        sample handshake; in_time/in_sig are the payload
//   start/stop/flush         one-cycle control pulses
//   sig_out                  held stimulus value
//   applied                  one-cycle pulse when sig_out is updated
//   late                     sticky flag: a sample was applied after its timestamp
//   underflow                sticky flag: the FIFO ran dry during playback
//   apply_count              saturating count of applied samples since start
//   running                  high in the RUN state
module stim_player #(
  parameter int TIME_WIDTH = 32,
  parameter int SIG_BITS   = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIME_WIDTH-1:0] time_curr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TIME_WIDTH-1:0] in_time,
  input  logic [SIG_BITS-1:0]   in_sig,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  flush,
  output logic [SIG_BITS-1:0]   sig_out,
  output logic                  applied,
  output logic                  late,
  output logic                  underflow,
  output logic [15:0]           apply_count,
  output logic                  running
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TIME_WIDTH-1:0] mem_time_q [DEPTH];
  logic [SIG_BITS-1:0]   mem_sig_q  [DEPTH];
  logic [SIG_BITS-1:0]   sig_out_q, sig_out_d;
  logic                  applied_q, applied_d;
  logic                  late_q, late_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           apply_count_q, apply_count_d;

  logic                  full, empty, push, pop, start_eff;
  logic [TIME_WIDTH-1:0] head_time;
  logic [SIG_BITS-1:0]   head_sig;
  logic [15:0]           cnt_base;

  // The extra pointer MSB distinguishes full (MSBs differ) from empty (MSBs equal).
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign head_time = mem_time_q[rd_ptr_q[AW-1:0]];
  assign head_sig  = mem_sig_q[rd_ptr_q[AW-1:0]];

  assign in_ready    = !full;
  assign sig_out     = sig_out_q;
  assign applied     = applied_q;
  assign late        = late_q;
  assign underflow   = underflow_q;
  assign apply_count = apply_count_q;
  assign running     = (state_q == RUN);

  always_comb begin
    // When start and stop arrive together, stop wins and the start is ignored
    // entirely: no state change and no clearing of the status flags.
    start_eff = start && !stop;

    state_d = state_q;
    if (stop)       state_d = IDLE;
    else if (start) state_d = RUN;

    // Flush dominates: a same-cycle push is dropped and a same-cycle pop is suppressed.
    push = in_valid && !full && !flush;
    pop  = (state_q == RUN) && !empty && (time_curr >= head_time) && !flush;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q;
    if (flush)    rd_ptr_d = wr_ptr_q;
    else if (pop) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};

    // Start clears the status before this cycle's pop or underflow updates it.
    cnt_base      = start_eff ? 16'd0 : apply_count_q;
    apply_count_d = cnt_base;
    late_d        = start_eff ? 1'b0 : late_q;
    underflow_d   = start_eff ? 1'b0 : underflow_q;
    applied_d     = pop;
    sig_out_d     = sig_out_q;

    if (pop) begin
      sig_out_d = head_sig;
      if (cnt_base != 16'hFFFF) apply_count_d = cnt_base + 16'd1;
      if (time_curr > head_time) late_d = 1'b1;
    end

    // A nonzero count means at least one sample has been applied since the last start.
    if ((state_q == RUN) && empty && (cnt_base != 16'd0)) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sig_out_q     <= '0;
      applied_q     <= 1'b0;
      late_q        <= 1'b0;
      underflow_q   <= 1'b0;
      apply_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sig_out_q     <= sig_out_d;
      applied_q     <= applied_d;
      late_q        <= late_d;
      underflow_q   <= underflow_d;
      apply_count_q <= apply_count_d;
    end
  end

  // The storage array has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_time_q[wr_ptr_q[AW-1:0]] <= in_time;
      mem_sig_q[wr_ptr_q[AW-1:0]]  <= in_sig;
    end
  end

endmodule
